io_mem_initiator: RTL and testbench
===================================

# io_mem_initiator

Requester-side engine for the accelerator memory request/response interface: accepts a block-transfer command (base word address, length, direction) and issues one request per word to the DMem-side controller, forwarding read responses onto an output stream or draining an input stream into write requests. Sits between an IO device datapath (e.g. conv2D feature/weight fetch and result writeback) and the IO DMem controller. Keeps at most one read outstanding, matching the responder's single-request protocol.

## Interface
- AWIDTH, 32, address width (word address)
- DWIDTH, 32, data width
- LWIDTH, 16, transfer length counter width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_addr  in  AWIDTH  base word address
- cmd_len  in  LWIDTH  number of words (0 legal)
- cmd_write  in  1  1 = write transfer, 0 = read transfer
- rd_data  out  DWIDTH  read stream data
- rd_valid  out  1  read stream valid
- rd_ready  in  1  read stream ready
- wr_data  in  DWIDTH  write stream data
- wr_valid  in  1  write stream valid
- wr_ready  out  1  write stream ready
- done  out  1  one-cycle pulse after final beat
- busy  out  1  high whenever not IDLE
- mem_req_addr  out  AWIDTH  request address
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  responder ready
- mem_req_data  out  DWIDTH  write data
- mem_req_write  out  1  request is write
- mem_resp_data  in  DWIDTH  response data
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  response accepted

## Operation
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, DONE.
- IDLE: cmd_ready=1. On cmd fire latch addr_q=cmd_addr, rem_q=cmd_len, write_q=cmd_write. Next state: DONE if cmd_len==0; else WR_REQ if cmd_write; else RD_REQ.
- RD_REQ: mem_req_valid=1, mem_req_write=0, mem_req_addr=addr_q. On req fire -> RD_RESP.
- RD_RESP: rd_valid=mem_resp_valid, rd_data=mem_resp_data, mem_resp_ready=rd_ready (pass-through, no buffering). On resp fire: addr_q+=1, rem_q-=1; -> DONE if rem_q==1, else RD_REQ.
- WR_REQ: mem_req_valid=wr_valid, wr_ready=mem_req_ready, mem_req_data=wr_data, mem_req_write=1, mem_req_addr=addr_q. On req fire: addr_q+=1, rem_q-=1; -> DONE if rem_q==1, else stay. No response expected for writes.
- DONE: done=1 for exactly one cycle, -> IDLE.
- Outside their states: mem_req_valid, mem_resp_ready, rd_valid, wr_ready, cmd_ready all 0 (cmd_ready 1 only in IDLE).
- mem_req_write = write_q in request states; mem_req_data = wr_data always.
- Address arithmetic modulo 2^AWIDTH (wraps silently); rem_q never underflows.

## Timing
- Reset: state=IDLE, addr_q=0, rem_q=0, write_q=0; outputs: cmd_ready=1, busy=0, done=0, all valid/ready outputs 0.
- Request fields held stable while mem_req_valid=1 and not fired.
- Read beat minimum 2 cycles (RD_REQ fire, then RD_RESP fire); with a 1-cycle responder, N reads take 2N cycles + 1 cmd + 1 DONE.
- Write beat minimum 2 cycles with the IO DMem controller (responder drops ready for its write cycle); the engine itself allows back-to-back fires if mem_req_ready stays high.
- rd_ready low stalls in RD_RESP indefinitely; response data must not be dropped.
- wr_valid low stalls in WR_REQ with mem_req_valid=0.
- Command with len 0: cmd fire cycle N, done=1 cycle N+1, cmd_ready=1 cycle N+2.
- New command not accepted during DONE.
- Reset mid-transfer: return to IDLE next edge, outstanding read abandoned; rst is shared with the responder, which resets alongside.

## Structure
- Shared header/package: state encodings (3-bit localparams) for IDLE/RD_REQ/RD_RESP/WR_REQ/DONE.
- State, addr_q, rem_q, write_q in REGISTER_R instances with reset values as above; next-state logic in one always @(*).
- No sub-module; single flat module.

## Test plan
- Read 4 words from addr 0x100 with the IO DMem controller + DMem model preloaded 0xA0..0xA3: rd stream yields 0xA0,0xA1,0xA2,0xA3 at addrs 0x100..0x103; done pulses once; total 10 cycles with rd_ready=1.
- Write 3 words 0x11,0x22,0x33 to 0x200: DMem holds them at 0x200..0x202, wbe=4'b1111 each write; mem_resp_ready never needed; done pulses once.
- Read 2 words with rd_ready toggled low 3 cycles per beat: data held stable, no loss, no duplicate requests.
- cmd_len=0 (read and write): no mem_req_valid ever, done 1 cycle after cmd fire.
- Write with wr_valid gaps and addr 0xFFFFFFFF, len 2: writes to 0xFFFFFFFF then 0x0.
- Assert rst during RD_RESP of a 4-word read: next cycle IDLE, cmd_ready=1, busy=0; new 1-word read then completes correctly.

Source files
------------

// File: rtl/io_mem_initiator_pkg.sv
// Shared definitions for the block-transfer memory request engine.
package io_mem_initiator_pkg;

  // Engine states; explicit 3-bit encodings keep debug dumps readable.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // State the engine enters right after a command is accepted.
  function automatic state_t first_state(input logic len_zero, input logic is_write);
    if (len_zero) begin
      return ST_DONE;
    end else if (is_write) begin
      return ST_WR_REQ;
    end
    return ST_RD_REQ;
  endfunction

endpackage

// File: rtl/io_mem_initiator.sv
// Requester-side block-transfer engine: one memory request per word, at most
// one read outstanding, reads passed straight through to the read stream and
// the write stream drained directly into write requests.
module io_mem_initiator
  import io_mem_initiator_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic              cmd_write,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              done,
  output logic              busy,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DWIDTH-1:0] mem_req_data,
  output logic              mem_req_write,
  input  logic [DWIDTH-1:0] mem_resp_data,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready
);

  state_t              state_reg, state_next;
  logic [AWIDTH-1:0]   addr_reg, addr_next;
  logic [LWIDTH-1:0]   rem_reg, rem_next;
  logic                write_reg, write_next;

  // The beat in flight is the last one when one word (or, defensively, none) remains.
  logic last_beat;
  assign last_beat = (rem_reg <= LWIDTH'(1));

  // State and transfer bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      write_reg <= write_next;
    end
  end

  // Next-state and handshake outputs; requests hold their fields until fired.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    rem_next       = rem_reg;
    write_next     = write_reg;
    cmd_ready      = 1'b0;
    rd_valid       = 1'b0;
    rd_data        = mem_resp_data;
    wr_ready       = 1'b0;
    done           = 1'b0;
    busy           = (state_reg != ST_IDLE);
    mem_req_addr   = addr_reg;
    mem_req_valid  = 1'b0;
    mem_req_data   = wr_data;
    mem_req_write  = 1'b0;
    mem_resp_ready = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_next  = cmd_addr;
          rem_next   = cmd_len;
          write_next = cmd_write;
          state_next = first_state(cmd_len == '0, cmd_write);
        end
      end

      ST_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = write_reg;
        if (mem_req_ready) begin
          state_next = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        // Pure pass-through: the response is only consumed when the stream takes it.
        rd_valid       = mem_resp_valid;
        mem_resp_ready = rd_ready;
        if (mem_resp_valid && rd_ready) begin
          addr_next  = addr_reg + AWIDTH'(1);
          rem_next   = (rem_reg != '0) ? rem_reg - LWIDTH'(1) : rem_reg;
          state_next = last_beat ? ST_DONE : ST_RD_REQ;
        end
      end

      ST_WR_REQ: begin
        mem_req_valid = wr_valid;
        wr_ready      = mem_req_ready;
        mem_req_write = write_reg;
        if (wr_valid && mem_req_ready) begin
          addr_next  = addr_reg + AWIDTH'(1);
          rem_next   = (rem_reg != '0) ? rem_reg - LWIDTH'(1) : rem_reg;
          state_next = last_beat ? ST_DONE : ST_WR_REQ;
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_io_mem_initiator.sv
// Self-checking bench for io_mem_initiator: cycle vectors plus transfers
// against a small single-request responder model.
module tb_io_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] rd_data, wr_data;
  logic        rd_valid, rd_ready, wr_valid, wr_ready;
  logic        done, busy;
  logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic        mem_resp_valid, mem_resp_ready;

  // Vector-driven responder side and model-driven responder side.
  logic        model_en;
  logic        v_req_ready, v_resp_valid;
  logic [31:0] v_resp_data;
  logic        m_pending, m_wr_hold;
  logic [31:0] m_data;
  logic [31:0] wmem [0:1023];
  int          m_rd_reqs = 0;
  int          m_wr_reqs = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int beats[$];
  int resp_rdy_wr;
  logic [31:0] wq [0:3];

  always #5 clk = ~clk;

  assign mem_req_ready  = model_en ? (!m_pending && !m_wr_hold) : v_req_ready;
  assign mem_resp_valid = model_en ? m_pending : v_resp_valid;
  assign mem_resp_data  = model_en ? m_data : v_resp_data;

  io_mem_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_write(cmd_write),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .done(done), .busy(busy),
    .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
    .mem_req_write(mem_req_write),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready)
  );

  // Read data "preloaded" in the memory: 0xA0 at 0x100, 0xA1 at 0x101, ...
  function automatic logic [31:0] rpat(input logic [31:0] a);
    return 32'hA0 + (a - 32'h100);
  endfunction

  // Responder model: one request at a time, read data one cycle later,
  // ready dropped for a cycle after each write.
  always @(posedge clk) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_wr_hold <= 1'b0;
      m_data    <= '0;
    end else if (model_en) begin
      m_wr_hold <= 1'b0;
      if (m_pending && mem_resp_ready) m_pending <= 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_write) begin
          wmem[mem_req_addr[9:0]] <= mem_req_data;
          m_wr_hold <= 1'b1;
          m_wr_reqs <= m_wr_reqs + 1;
        end else begin
          m_pending <= 1'b1;
          m_data    <= rpat(mem_req_addr);
          m_rd_reqs <= m_rd_reqs + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus with its expected combinational outputs.
  // exp = {cmd_ready, busy, done, req_valid, req_write, wr_ready, rd_valid, resp_ready}
  typedef struct {
    logic        cv;
    logic [15:0] len;
    logic        cw;
    logic [31:0] addr;
    logic        rdy;
    logic        wv;
    logic [31:0] wd;
    logic        qrdy;
    logic        rsv;
    logic [31:0] rsd;
    logic [7:0]  exp;
    logic        ca;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mkv(input logic cv, input logic [15:0] len, input logic cw,
                               input logic [31:0] addr, input logic rdy, input logic wv,
                               input logic [31:0] wd, input logic qrdy, input logic rsv,
                               input logic [31:0] rsd, input logic [7:0] exp,
                               input logic ca, input logic [31:0] eaddr);
    vec_t v;
    v.cv = cv; v.len = len; v.cw = cw; v.addr = addr; v.rdy = rdy; v.wv = wv;
    v.wd = wd; v.qrdy = qrdy; v.rsv = rsv; v.rsd = rsd; v.exp = exp;
    v.ca = ca; v.eaddr = eaddr;
    return v;
  endfunction

  // Issue one command and run it to completion against the responder model.
  task automatic run_xfer(input logic [31:0] a, input logic [15:0] n, input logic w,
                          input bit stall, output int busy_cyc, output int done_cnt);
    int stall_cnt;
    int widx;
    bit ok;
    logic [31:0] held;
    beats.delete();
    busy_cyc = 0; done_cnt = 0; stall_cnt = 0; widx = 0; resp_rdy_wr = 0; held = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = n; cmd_write = w;
    rd_ready = 1'b1; wr_valid = w; wr_data = wq[0];
    #1 check("xfer_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      busy_cyc++;
      if (done) done_cnt++;
      if (w && mem_resp_ready) resp_rdy_wr++;
      if (stall && rd_valid && stall_cnt < 3) begin
        if (stall_cnt == 0) held = rd_data;
        else check("stall_data_stable", rd_data, held);
        rd_ready = 1'b0;
        stall_cnt++;
      end else begin
        rd_ready = 1'b1;
      end
      wr_data  = (widx < 4) ? wq[widx] : 32'd0;
      wr_valid = w;
      #1;
      if (rd_valid && rd_ready) begin
        if (stall) check("stall_fire_data", rd_data, held);
        beats.push_back(int'(rd_data));
        stall_cnt = 0;
      end
      if (wr_valid && wr_ready) widx++;
    end
    if (!ok) check("xfer_timeout", 32'd1, 32'd0);
    $display("xfer addr=%h len=%0d write=%0d busy_cycles=%0d done=%0d beats=%0d",
             a, n, w, busy_cyc, done_cnt, beats.size());
  endtask

  vec_t vecs [0:22];

  initial begin
    int bc, dc, rd0, wr0;
    vecs[0]  = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[1]  = mkv(1, 0, 0, 32'h55,       0, 0, 32'h0,  0, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[2]  = mkv(1, 0, 0, 32'h66,       0, 0, 32'h0,  1, 0, 32'h0,    8'b0110_0000, 0, 32'h0);
    vecs[3]  = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[4]  = mkv(1, 0, 1, 32'h77,       0, 1, 32'h5,  1, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[5]  = mkv(0, 0, 0, 32'h0,        0, 1, 32'h5,  1, 0, 32'h0,    8'b0110_0000, 0, 32'h0);
    vecs[6]  = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[7]  = mkv(1, 2, 1, 32'hFFFFFFFF, 0, 0, 32'h0,  0, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[8]  = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 32'h0,    8'b0100_1100, 1, 32'hFFFFFFFF);
    vecs[9]  = mkv(0, 0, 0, 32'h0,        0, 1, 32'h11, 0, 0, 32'h0,    8'b0101_1000, 1, 32'hFFFFFFFF);
    vecs[10] = mkv(0, 0, 0, 32'h0,        0, 1, 32'h11, 1, 0, 32'h0,    8'b0101_1100, 1, 32'hFFFFFFFF);
    vecs[11] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 32'h0,    8'b0100_1100, 1, 32'h0);
    vecs[12] = mkv(0, 0, 0, 32'h0,        0, 1, 32'h22, 1, 0, 32'h0,    8'b0101_1100, 1, 32'h0);
    vecs[13] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 32'h0,    8'b0110_0000, 0, 32'h0);
    vecs[14] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[15] = mkv(1, 1, 0, 32'h10,       0, 0, 32'h0,  0, 0, 32'h0,    8'b1000_0000, 0, 32'h0);
    vecs[16] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    8'b0101_0000, 1, 32'h10);
    vecs[17] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 32'h0,    8'b0101_0000, 1, 32'h10);
    vecs[18] = mkv(0, 0, 0, 32'h0,        1, 0, 32'h0,  0, 0, 32'h0,    8'b0100_0001, 0, 32'h0);
    vecs[19] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 32'hBEEF, 8'b0100_0010, 0, 32'h0);
    vecs[20] = mkv(0, 0, 0, 32'h0,        1, 0, 32'h0,  0, 1, 32'hBEEF, 8'b0100_0011, 0, 32'h0);
    vecs[21] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    8'b0110_0000, 0, 32'h0);
    vecs[22] = mkv(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    8'b1000_0000, 0, 32'h0);

    model_en = 1'b0;
    v_req_ready = 1'b0; v_resp_valid = 1'b0; v_resp_data = '0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_write = 1'b0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cycle vectors: reset state, zero-length commands, wrapping write, single read.
    for (int i = 0; i < 23; i++) begin
      if (i > 0) @(negedge clk);
      cmd_valid = vecs[i].cv; cmd_len = vecs[i].len; cmd_write = vecs[i].cw;
      cmd_addr = vecs[i].addr; rd_ready = vecs[i].rdy; wr_valid = vecs[i].wv;
      wr_data = vecs[i].wd; v_req_ready = vecs[i].qrdy; v_resp_valid = vecs[i].rsv;
      v_resp_data = vecs[i].rsd;
      #1;
      check($sformatf("v%0d_cmd_ready", i),  {31'd0, cmd_ready},      {31'd0, vecs[i].exp[7]});
      check($sformatf("v%0d_busy", i),       {31'd0, busy},           {31'd0, vecs[i].exp[6]});
      check($sformatf("v%0d_done", i),       {31'd0, done},           {31'd0, vecs[i].exp[5]});
      check($sformatf("v%0d_req_valid", i),  {31'd0, mem_req_valid},  {31'd0, vecs[i].exp[4]});
      check($sformatf("v%0d_wr_ready", i),   {31'd0, wr_ready},       {31'd0, vecs[i].exp[2]});
      check($sformatf("v%0d_rd_valid", i),   {31'd0, rd_valid},       {31'd0, vecs[i].exp[1]});
      check($sformatf("v%0d_resp_ready", i), {31'd0, mem_resp_ready}, {31'd0, vecs[i].exp[0]});
      if (vecs[i].exp[4] || vecs[i].exp[2])
        check($sformatf("v%0d_req_write", i), {31'd0, mem_req_write}, {31'd0, vecs[i].exp[3]});
      if (vecs[i].ca) check($sformatf("v%0d_req_addr", i), mem_req_addr, vecs[i].eaddr);
      if (vecs[i].exp[4] && vecs[i].exp[3]) check($sformatf("v%0d_req_data", i), mem_req_data, vecs[i].wd);
      if (vecs[i].exp[1]) check($sformatf("v%0d_rd_data", i), rd_data, vecs[i].rsd);
      $display("vec %0d applied", i);
    end

    @(negedge clk);
    rd_ready = 1'b0; wr_valid = 1'b0; v_req_ready = 1'b0; v_resp_valid = 1'b0;
    model_en = 1'b1;

    // 4-word read from 0x100 with a 1-cycle responder.
    rd0 = m_rd_reqs;
    run_xfer(32'h100, 16'd4, 1'b0, 1'b0, bc, dc);
    check("rd4_beats", beats.size(), 4);
    for (int k = 0; k < 4 && k < beats.size(); k++)
      check($sformatf("rd4_beat%0d", k), beats[k], 32'hA0 + k);
    check("rd4_busy_cycles", bc, 9);
    check("rd4_done_pulses", dc, 1);
    check("rd4_requests", m_rd_reqs - rd0, 4);

    // 3-word write to 0x200.
    wq[0] = 32'h11; wq[1] = 32'h22; wq[2] = 32'h33; wq[3] = 32'h0;
    wr0 = m_wr_reqs;
    run_xfer(32'h200, 16'd3, 1'b1, 1'b0, bc, dc);
    check("wr3_mem0", wmem[10'h200], 32'h11);
    check("wr3_mem1", wmem[10'h201], 32'h22);
    check("wr3_mem2", wmem[10'h202], 32'h33);
    check("wr3_requests", m_wr_reqs - wr0, 3);
    check("wr3_done_pulses", dc, 1);
    check("wr3_no_resp_ready", resp_rdy_wr, 0);

    // 2-word read with rd_ready held low 3 cycles per beat.
    rd0 = m_rd_reqs;
    run_xfer(32'h102, 16'd2, 1'b0, 1'b1, bc, dc);
    check("stall_beats", beats.size(), 2);
    for (int k = 0; k < 2 && k < beats.size(); k++)
      check($sformatf("stall_beat%0d", k), beats[k], 32'hA2 + k);
    check("stall_requests", m_rd_reqs - rd0, 2);
    check("stall_done_pulses", dc, 1);

    // Reset while a read response is stalled.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_len = 16'd4; cmd_write = 1'b0; rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (mem_resp_valid) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("rst_reached_rd_resp", {31'd0, seen}, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    $display("reset applied during read response");

    rd0 = m_rd_reqs;
    run_xfer(32'h101, 16'd1, 1'b0, 1'b0, bc, dc);
    check("post_rst_beats", beats.size(), 1);
    if (beats.size() > 0) check("post_rst_data", beats[0], 32'hA1);
    check("post_rst_done", dc, 1);
    check("post_rst_requests", m_rd_reqs - rd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
